// File: rtl/tx_port_channel_gate_256.sv
// Purpose : channel-facing TX entry stage; serialises one user transaction into an event/data FIFO.
// Latency : CHNL_TX rise -> open event #1 in FIFO 1 cycle; -> CHNL_TX_ACK 2 cycles (FIFO not full).
// Backpr. : writes stall while the FIFO is full; CHNL_TX_DATA_REN drops and close events wait for space.
//
// Ports:
//   CLK, RST            sole clock; synchronous active-high reset (flushes FIFO, drops partial txn)
//   CHNL_TX             user opens/holds a transaction; dropping it closes the transaction
//   CHNL_TX_ACK         one-cycle pulse once both open events are queued
//   CHNL_TX_LAST/LEN/OFF  transaction attributes, captured when open event #1 is written
//   CHNL_TX_DATA[_VALID]  payload beat; accepted when CHNL_TX_DATA_REN is also high
//   EVT_DATA            registered FIFO head {evt_flag, payload}, updated the cycle after a pop
//   EVT_DATA_EMPTY      FIFO holds no entries
//   EVT_DATA_RD_EN      pop request from the downstream monitor
module tx_port_channel_gate_256 #(
  parameter int C_DATA_WIDTH = 256,
  parameter int C_FIFO_DEPTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CHNL_TX,
  output logic                    CHNL_TX_ACK,
  input  logic                    CHNL_TX_LAST,
  input  logic [31:0]             CHNL_TX_LEN,
  input  logic [30:0]             CHNL_TX_OFF,
  input  logic [C_DATA_WIDTH-1:0] CHNL_TX_DATA,
  input  logic                    CHNL_TX_DATA_VALID,
  output logic                    CHNL_TX_DATA_REN,
  output logic [C_DATA_WIDTH:0]   EVT_DATA,
  output logic                    EVT_DATA_EMPTY,
  input  logic                    EVT_DATA_RD_EN
);

  localparam int C_FIFO_DEPTH_WIDTH = $clog2(C_FIFO_DEPTH) + 1;
  localparam int PTR_W              = $clog2(C_FIFO_DEPTH);
  localparam logic [C_FIFO_DEPTH_WIDTH-1:0] DEPTH_C    = C_FIFO_DEPTH_WIDTH'(C_FIFO_DEPTH);
  localparam logic [C_FIFO_DEPTH_WIDTH-1:0] DEPTH_M2_C = C_FIFO_DEPTH_WIDTH'(C_FIFO_DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPEN_2  = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSE_1 = 3'd3,
    S_CLOSE_2 = 3'd4
  } state_e;

  // Event entries: flag bit set, 64-bit event word in the low bits, rest zero.
  function automatic logic [C_DATA_WIDTH:0] evt_entry(input logic [63:0] word);
    logic [C_DATA_WIDTH:0] e;
    e               = '0;
    e[C_DATA_WIDTH] = 1'b1;
    e[63:0]         = word;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Channel FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [30:0] off_q, off_d;
  logic        last_q, last_d;
  logic [31:0] beat_q, beat_d;
  logic        ack_q, ack_d;
  logic        ren;

  logic                          wr_en;
  logic [C_DATA_WIDTH:0]         wr_dat;
  logic                          full;
  logic [C_FIFO_DEPTH_WIDTH-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      off_q   <= '0;
      last_q  <= 1'b0;
      beat_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      off_q   <= off_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    off_d   = off_q;
    last_d  = last_q;
    beat_d  = beat_q;
    ack_d   = 1'b0;
    ren     = 1'b0;
    wr_en   = 1'b0;
    wr_dat  = '0;

    case (state_q)
      S_IDLE: begin
        // Need room for both open events before committing, so the pair is never split by a full FIFO.
        if (CHNL_TX && (count_q <= DEPTH_M2_C)) begin
          wr_en   = 1'b1;
          wr_dat  = evt_entry({CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_LAST});
          len_d   = CHNL_TX_LEN;
          off_d   = CHNL_TX_OFF;
          last_d  = CHNL_TX_LAST;
          beat_d  = '0;
          state_d = S_OPEN_2;
        end
      end

      S_OPEN_2: begin
        wr_en  = 1'b1;
        wr_dat = evt_entry({len_q, off_q, last_q});
        if (!full) begin
          // Registered, so the ACK is seen in the first OPEN cycle.
          ack_d   = 1'b1;
          state_d = S_OPEN;
        end
      end

      S_OPEN: begin
        if (!CHNL_TX) begin
          state_d = S_CLOSE_1;
        end else begin
          ren = !full;
          if (CHNL_TX_DATA_VALID && !full) begin
            wr_en  = 1'b1;
            wr_dat = {1'b0, CHNL_TX_DATA};
            beat_d = beat_q + 32'd1;
          end
        end
      end

      S_CLOSE_1: begin
        wr_en  = 1'b1;
        wr_dat = evt_entry({32'd0, beat_q});
        if (!full) begin
          state_d = S_CLOSE_2;
        end
      end

      S_CLOSE_2: begin
        wr_en  = 1'b1;
        wr_dat = evt_entry({32'd0, beat_q});
        if (!full) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Event/data FIFO with registered head
  // ---------------------------------------------------------------------------
  logic [C_DATA_WIDTH:0] mem [C_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [C_DATA_WIDTH:0] evt_data_q;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count_q == DEPTH_C);
  // A full FIFO refuses writes even when a pop happens in the same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = EVT_DATA_RD_EN && (count_q != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      evt_data_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        evt_data_q <= mem[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + C_FIFO_DEPTH_WIDTH'(1);
        2'b01:   count_q <= count_q - C_FIFO_DEPTH_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && wr_ok) begin
      mem[wr_ptr_q] <= wr_dat;
    end
  end

  assign EVT_DATA         = evt_data_q;
  assign EVT_DATA_EMPTY   = (count_q == '0);
  assign CHNL_TX_ACK      = ack_q;
  assign CHNL_TX_DATA_REN = ren;

endmodule
